// File: rtl/diff_demo_pkg.sv
// Shared types for the layer sequencer: layer table entry and FSM state encoding.
package diff_demo_pkg;

  // Field width of the stored layer table entries; the sequencer's DIM_W should match.
  localparam int unsigned CfgDimW = 8;

  typedef struct packed {
    logic [CfgDimW-1:0] w;
    logic [CfgDimW-1:0] h;
    logic [CfgDimW-1:0] c;
    logic [CfgDimW-1:0] co;
    logic               kernel_mode;
  } layer_cfg_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StNext,
    StDone
  } seq_state_e;

endpackage

// File: rtl/core_layer_col_cnt.sv
// Per-column input walker: steps w/h within a tile, then strides the channel index by
// NUM_COL across ci/co tiles until this column has covered all of its output channels.
module core_layer_col_cnt #(
  parameter int unsigned NUM_COL = 4,
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned COL_IDX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic               act_en,
  input  logic [DIM_W-1:0]   w,
  input  logic [DIM_W-1:0]   h,
  input  logic [DIM_W-1:0]   c,
  input  logic [DIM_W-1:0]   co,
  output logic               col_done,
  output logic [2*DIM_W-1:0] fm_rd_addr
);

  // One extra bit so cnt_ci + NUM_COL never wraps.
  localparam int unsigned CW = DIM_W + 1;

  logic [CW-1:0]      cnt_w_q, cnt_w_d;
  logic [CW-1:0]      cnt_h_q, cnt_h_d;
  logic [CW-1:0]      cnt_ci_q, cnt_ci_d;
  logic [CW-1:0]      cnt_co_q, cnt_co_d;
  logic [2*DIM_W-1:0] addr_q, addr_d;
  logic               done_q, done_d;

  logic [CW-1:0] w_x, h_x, c_x, co_x, ci_sum, co_inc;

  assign w_x    = {1'b0, w};
  assign h_x    = {1'b0, h};
  assign c_x    = {1'b0, c};
  assign co_x   = {1'b0, co};
  assign ci_sum = cnt_ci_q + CW'(NUM_COL);
  assign co_inc = cnt_co_q + CW'(1);

  // Counter next-state: load at layer start, advance on each accepted activation.
  always_comb begin
    cnt_w_d  = cnt_w_q;
    cnt_h_d  = cnt_h_q;
    cnt_ci_d = cnt_ci_q;
    cnt_co_d = cnt_co_q;
    addr_d   = addr_q;
    done_d   = done_q;
    if (load) begin
      cnt_w_d  = w_x;
      cnt_h_d  = h_x;
      cnt_ci_d = CW'(COL_IDX);
      cnt_co_d = '0;
      addr_d   = '0;
      done_d   = (CW'(COL_IDX) >= c_x);
    end else if (run && act_en && !done_q) begin
      if (cnt_w_q > CW'(1)) begin
        cnt_w_d = cnt_w_q - CW'(1);
        addr_d  = addr_q + (2*DIM_W)'(1);
      end else if (cnt_h_q > CW'(1)) begin
        cnt_w_d = w_x;
        cnt_h_d = cnt_h_q - CW'(1);
        addr_d  = addr_q + (2*DIM_W)'(1);
      end else begin
        // End of tile: rewind the tile walk and stride to the next channel.
        cnt_w_d = w_x;
        cnt_h_d = h_x;
        addr_d  = '0;
        if (ci_sum >= c_x) begin
          cnt_ci_d = ci_sum - c_x;
          cnt_co_d = co_inc;
          if (co_inc == co_x) begin
            done_d = 1'b1;
          end
        end else begin
          cnt_ci_d = ci_sum;
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_w_q  <= '0;
      cnt_h_q  <= '0;
      cnt_ci_q <= '0;
      cnt_co_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_w_q  <= cnt_w_d;
      cnt_h_q  <= cnt_h_d;
      cnt_ci_q <= cnt_ci_d;
      cnt_co_q <= cnt_co_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

  assign col_done   = done_q;
  assign fm_rd_addr = addr_q;

endmodule

// File: rtl/core_layer_seq.sv
// Layer sequencer: walks a programmable layer table, drives per-layer parameters and
// per-column read counters, and retires each layer on column completion plus write-back.
// Optional run cycle counter is built only when CORE_LAYER_SEQ_PERF_EN is defined.
module core_layer_seq
  import diff_demo_pkg::*;
#(
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned NUM_ROW    = 4,
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned DIM_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_wr_en,
  input  logic [$clog2(MAX_LAYERS)-1:0]       cfg_wr_idx,
  input  layer_cfg_t                          cfg_wr_data,
  input  logic [$clog2(MAX_LAYERS):0]         cfg_num_layers,
  input  logic                                start_valid,
  output logic                                start_ready,
  input  logic                                start_ping_pong,
  input  logic                                start_bit_mode,
  output logic                                busy,
  output logic                                done,
  output logic [DIM_W-1:0]                    w_num,
  output logic [DIM_W-1:0]                    h_num,
  output logic [DIM_W-1:0]                    c_num,
  output logic [DIM_W-1:0]                    co_num,
  output logic                                kernel_mode,
  output logic                                bit_mode,
  output logic                                ping_pong,
  output logic [$clog2(MAX_LAYERS)-1:0]       layer_idx,
  output logic                                layer_start,
  input  logic [NUM_COL-1:0]                  act_en,
  output logic [NUM_COL-1:0]                  col_done,
  output logic [NUM_COL-1:0][2*DIM_W-1:0]     fm_rd_addr,
  input  logic [NUM_ROW-1:0]                  wb_finish,
  output logic [31:0]                         perf_cycles
);

  localparam int unsigned IdxW = $clog2(MAX_LAYERS);
  localparam logic [DIM_W:0] NumRowW = (DIM_W+1)'(NUM_ROW);

  seq_state_e           state_q, state_d;
  logic [IdxW-1:0]      layer_idx_q, layer_idx_d;
  logic                 ping_pong_q, ping_pong_d;
  logic                 bit_mode_q, bit_mode_d;
  logic [NUM_ROW-1:0]   wb_seen_q, wb_seen_d;
  logic [DIM_W:0]       co_left_q, co_left_d;
  layer_cfg_t           table_q [MAX_LAYERS];

  layer_cfg_t           cur_cfg;
  logic [NUM_ROW-1:0]   wb_any;
  logic                 round_complete;
  logic                 layer_finish;
  logic                 accept;
  logic [IdxW:0]        next_idx;

  assign cur_cfg        = table_q[layer_idx_q];
  assign accept         = (state_q == StIdle) && start_valid;
  assign next_idx       = {1'b0, layer_idx_q} + (IdxW+1)'(1);
  assign wb_any         = wb_seen_q | wb_finish;
  assign round_complete = &wb_any;
  assign layer_finish   = (&col_done) && round_complete && (co_left_q <= NumRowW);

  // Layer table is deliberately not reset; it only accepts writes between runs.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state_q == StIdle)) begin
      table_q[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // Sequencer next-state and per-run context.
  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    ping_pong_d = ping_pong_q;
    bit_mode_d  = bit_mode_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          ping_pong_d = start_ping_pong;
          bit_mode_d  = start_bit_mode;
          layer_idx_d = '0;
          state_d     = (cfg_num_layers == '0) ? StDone : StLoad;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        if (layer_finish) begin
          state_d = StNext;
        end
      end
      StNext: begin
        layer_idx_d = next_idx[IdxW-1:0];
        ping_pong_d = ~ping_pong_q;
        state_d     = (next_idx < cfg_num_layers) ? StLoad : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write-back round tracking and remaining output-channel budget.
  always_comb begin
    wb_seen_d = round_complete ? '0 : wb_any;
    co_left_d = co_left_q;
    if (state_q == StLoad) begin
      co_left_d = (DIM_W+1)'(cur_cfg.co);
    end else if (round_complete) begin
      co_left_d = (co_left_q > NumRowW) ? (co_left_q - NumRowW) : '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      layer_idx_q <= '0;
      ping_pong_q <= 1'b0;
      bit_mode_q  <= 1'b0;
      wb_seen_q   <= '0;
      co_left_q   <= '0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      ping_pong_q <= ping_pong_d;
      bit_mode_q  <= bit_mode_d;
      wb_seen_q   <= wb_seen_d;
      co_left_q   <= co_left_d;
    end
  end

  for (genvar j = 0; j < NUM_COL; j++) begin : g_col
    core_layer_col_cnt #(
      .NUM_COL (NUM_COL),
      .DIM_W   (DIM_W),
      .COL_IDX (j)
    ) u_col_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (state_q == StLoad),
      .run        (state_q == StRun),
      .act_en     (act_en[j]),
      .w          (w_num),
      .h          (h_num),
      .c          (c_num),
      .co         (co_num),
      .col_done   (col_done[j]),
      .fm_rd_addr (fm_rd_addr[j])
    );
  end

`ifdef CORE_LAYER_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Run cycle counter: cleared on accept, holds its final value once idle.
  always_comb begin
    perf_d = perf_q;
    if (accept) begin
      perf_d = '0;
    end else if (busy) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Run cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign start_ready = (state_q == StIdle);
  assign busy        = ~start_ready;
  assign done        = (state_q == StDone);
  assign layer_start = (state_q == StLoad);
  assign layer_idx   = layer_idx_q;
  assign ping_pong   = ping_pong_q;
  assign bit_mode    = bit_mode_q;
  assign w_num       = DIM_W'(cur_cfg.w);
  assign h_num       = DIM_W'(cur_cfg.h);
  assign c_num       = DIM_W'(cur_cfg.c);
  assign co_num      = DIM_W'(cur_cfg.co);
  assign kernel_mode = cur_cfg.kernel_mode;

endmodule

// File: tb/tb_core_layer_seq.sv
// Self-checking bench for core_layer_seq: directed scenarios plus randomized layer tables
// and activation/write-back traffic checked against a tile-level reference model.
module tb_core_layer_seq;
  import diff_demo_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned NR = 4;
  localparam int unsigned ML = 8;
  localparam int unsigned DW = 8;
  localparam int          Budget = 3000;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_wr_en;
  logic [2:0]          cfg_wr_idx;
  layer_cfg_t          cfg_wr_data;
  logic [3:0]          cfg_num_layers;
  logic                start_valid, start_ready, start_ping_pong, start_bit_mode;
  logic                busy, done;
  logic [DW-1:0]       w_num, h_num, c_num, co_num;
  logic                kernel_mode, bit_mode, ping_pong;
  logic [2:0]          layer_idx;
  logic                layer_start;
  logic [NC-1:0]       act_en, col_done;
  logic [NC-1:0][2*DW-1:0] fm_rd_addr;
  logic [NR-1:0]       wb_finish;
  logic [31:0]         perf_cycles;

  always #5 clk = ~clk;

  core_layer_seq #(
    .NUM_COL    (NC),
    .NUM_ROW    (NR),
    .MAX_LAYERS (ML),
    .DIM_W      (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_idx      (cfg_wr_idx),
    .cfg_wr_data     (cfg_wr_data),
    .cfg_num_layers  (cfg_num_layers),
    .start_valid     (start_valid),
    .start_ready     (start_ready),
    .start_ping_pong (start_ping_pong),
    .start_bit_mode  (start_bit_mode),
    .busy            (busy),
    .done            (done),
    .w_num           (w_num),
    .h_num           (h_num),
    .c_num           (c_num),
    .co_num          (co_num),
    .kernel_mode     (kernel_mode),
    .bit_mode        (bit_mode),
    .ping_pong       (ping_pong),
    .layer_idx       (layer_idx),
    .layer_start     (layer_start),
    .act_en          (act_en),
    .col_done        (col_done),
    .fm_rd_addr      (fm_rd_addr),
    .wb_finish       (wb_finish),
    .perf_cycles     (perf_cycles)
  );

  layer_cfg_t tbl [ML];
  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  function automatic int tile_len(input int w, input int h);
    return (w < 1 ? 1 : w) * (h < 1 ? 1 : h);
  endfunction

  // Number of tiles column j walks: channel index strides by NC; every wrap past c
  // completes one output channel, and the column retires after co of them.
  function automatic int tiles_for_col(input int j, input int c, input int co);
    int ci, cc, n;
    if (j >= c) return 0;
    ci = j; cc = 0; n = 0;
    while (cc < co) begin
      n++;
      if (ci + int'(NC) >= c) begin
        ci = ci + int'(NC) - c;
        cc++;
      end else begin
        ci = ci + int'(NC);
      end
    end
    return n;
  endfunction

  function automatic layer_cfg_t rand_cfg();
    layer_cfg_t e;
    e.w           = 8'($urandom_range(1, 3));
    e.h           = 8'($urandom_range(1, 3));
    e.c           = 8'($urandom_range(0, 6));
    e.co          = 8'($urandom_range(1, 6));
    e.kernel_mode = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic write_entry(input int idx, input layer_cfg_t e);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = 3'(idx);
    cfg_wr_data = e;
    tick();
    cfg_wr_en   = 1'b0;
    tbl[idx]    = e;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_start_ready"}, 64'(start_ready), 64'(1));
    check_eq({tag, "_busy"},        64'(busy),        64'(0));
    check_eq({tag, "_done"},        64'(done),        64'(0));
    check_eq({tag, "_layer_start"}, 64'(layer_start), 64'(0));
    check_eq({tag, "_layer_idx"},   64'(layer_idx),   64'(0));
    check_eq({tag, "_ping_pong"},   64'(ping_pong),   64'(0));
    check_eq({tag, "_bit_mode"},    64'(bit_mode),    64'(0));
    check_eq({tag, "_col_done"},    64'(col_done),    64'(0));
    check_eq({tag, "_fm_rd_addr"},  64'(fm_rd_addr),  64'(0));
    check_eq({tag, "_perf"},        64'(perf_cycles), 64'(0));
  endtask

  // mode 0: random traffic with stray table writes; 1: full streaming with periodic
  // write-back rounds; 2: staggered write-back (row 0 early, all rows two cycles later).
  // abort_at >= 0 pulses reset at that RUN cycle of layer 0.
  task automatic run_seq(input int nl, input bit ping, input bit bm, input int mode,
                         input int abort_at);
    int acts [NC];
    int tiles [NC];
    bit cd [NC];
    int tl, c, co, rounds, co_left, cyc;
    logic [NR-1:0] seen, any;
    bit fin, all_done;
    int exp_perf;

    cfg_num_layers  = 4'(nl);
    start_ping_pong = ping;
    start_bit_mode  = bm;
    start_valid     = 1'b1;
    check_eq("accept_ready", 64'(start_ready), 64'(1));
    tick();
    start_valid = 1'b0;
    ticks = 0;

    if (nl == 0) begin
      check_eq("empty_done", 64'(done), 64'(1));
      check_eq("empty_layer_start", 64'(layer_start), 64'(0));
      check_eq("empty_busy", 64'(busy), 64'(1));
      tick();
      check_eq("empty_done_clr", 64'(done), 64'(0));
      check_eq("empty_ready", 64'(start_ready), 64'(1));
    end else begin
      for (int l = 0; l < nl; l++) begin
        // LOAD cycle
        check_eq("load_layer_start", 64'(layer_start), 64'(1));
        check_eq("load_layer_idx", 64'(layer_idx), 64'(l));
        check_eq("load_ping_pong", 64'(ping_pong), 64'(ping ^ l[0]));
        check_eq("load_bit_mode", 64'(bit_mode), 64'(bm));
        check_eq("load_w", 64'(w_num), 64'(tbl[l].w));
        check_eq("load_h", 64'(h_num), 64'(tbl[l].h));
        check_eq("load_c", 64'(c_num), 64'(tbl[l].c));
        check_eq("load_co", 64'(co_num), 64'(tbl[l].co));
        check_eq("load_kernel", 64'(kernel_mode), 64'(tbl[l].kernel_mode));
        tick();

        c  = int'(tbl[l].c);
        co = int'(tbl[l].co);
        tl = tile_len(int'(tbl[l].w), int'(tbl[l].h));
        for (int j = 0; j < int'(NC); j++) begin
          acts[j]  = 0;
          tiles[j] = tiles_for_col(j, c, co);
        end
        seen = '0; rounds = 0; fin = 1'b0; cyc = 0;

        while (!fin) begin
          all_done = 1'b1;
          for (int j = 0; j < int'(NC); j++) begin
            cd[j] = (j >= c) || (acts[j] >= tiles[j] * tl);
            all_done &= cd[j];
            check_eq($sformatf("col_done[%0d]", j), 64'(col_done[j]), 64'(cd[j]));
            check_eq($sformatf("fm_rd_addr[%0d]", j), 64'(fm_rd_addr[j]), 64'(acts[j] % tl));
          end
          check_eq("run_layer_start", 64'(layer_start), 64'(0));
          check_eq("run_busy", 64'(busy), 64'(1));
          check_eq("wb_seen", 64'(dut.wb_seen_q), 64'(seen));

          if (l == 0 && cyc == abort_at) begin
            act_en = '0; wb_finish = '0; cfg_wr_en = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_state("abort");
            check_eq("abort_tbl_w", 64'(w_num), 64'(tbl[0].w));
            check_eq("abort_tbl_co", 64'(co_num), 64'(tbl[0].co));
            tick();
            check_eq("abort_no_done", 64'(done), 64'(0));
            return;
          end
          if (cyc > Budget) begin
            check_eq("run_timeout", 64'(fin), 64'(1));
            act_en = '0; wb_finish = '0; cfg_wr_en = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            return;
          end

          case (mode)
            1: begin
              act_en    = '1;
              wb_finish = (cyc % 5 == 4) ? '1 : '0;
            end
            2: begin
              act_en    = '1;
              wb_finish = (cyc % 6 == 2) ? 4'b0001 : ((cyc % 6 == 4) ? 4'b1111 : 4'b0000);
            end
            default: begin
              act_en      = 4'($urandom_range(0, 15));
              wb_finish   = 4'($urandom_range(0, 15));
              cfg_wr_en   = ($urandom_range(0, 7) == 0);
              cfg_wr_idx  = 3'($urandom_range(0, 7));
              cfg_wr_data = rand_cfg();
            end
          endcase

          any     = seen | wb_finish;
          co_left = (co - rounds * int'(NR)) > 0 ? (co - rounds * int'(NR)) : 0;
          fin     = all_done && (&any) && (co_left <= int'(NR));
          for (int j = 0; j < int'(NC); j++) begin
            if (act_en[j] && !cd[j]) acts[j]++;
          end
          if (&any) begin
            rounds++;
            seen = '0;
          end else begin
            seen = any;
          end
          tick();
          cyc++;
        end
        act_en = '0; wb_finish = '0; cfg_wr_en = 1'b0;

        // NEXT cycle
        check_eq("next_layer_start", 64'(layer_start), 64'(0));
        check_eq("next_done", 64'(done), 64'(0));
        check_eq("next_busy", 64'(busy), 64'(1));
        tick();
      end
      check_eq("done_pulse", 64'(done), 64'(1));
      check_eq("done_layer_start", 64'(layer_start), 64'(0));
      tick();
      check_eq("done_clr", 64'(done), 64'(0));
      check_eq("idle_ready", 64'(start_ready), 64'(1));
    end
`ifdef CORE_LAYER_SEQ_PERF_EN
    exp_perf = ticks;
`else
    exp_perf = 0;
`endif
    check_eq("perf_cycles", 64'(perf_cycles), 64'(exp_perf));
    tick();
    check_eq("perf_hold", 64'(perf_cycles), 64'(exp_perf));
  endtask

  initial begin
    layer_cfg_t e;
    rst = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0; cfg_num_layers = '0;
    start_valid = 1'b0; start_ping_pong = 1'b0; start_bit_mode = 1'b0;
    act_en = '0; wb_finish = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Single layer, full streaming: 16 activations per column, four write-back rounds.
    e = '{w: 8'd2, h: 8'd2, c: 8'd4, co: 8'd4, kernel_mode: 1'b1};
    write_entry(0, e);
    run_seq(1, 1'b0, 1'b0, 1, -1);

    // Three layers starting on bank 1.
    write_entry(1, rand_cfg());
    write_entry(2, rand_cfg());
    run_seq(3, 1'b1, 1'b1, 0, -1);

    // Fewer channels than columns: last column idle from the start.
    e = '{w: 8'd2, h: 8'd1, c: 8'd3, co: 8'd2, kernel_mode: 1'b0};
    write_entry(0, e);
    run_seq(1, 1'b0, 1'b1, 0, -1);

    // Staggered write-back rows collapse into a single round.
    e = '{w: 8'd2, h: 8'd2, c: 8'd4, co: 8'd4, kernel_mode: 1'b1};
    write_entry(0, e);
    run_seq(1, 1'b0, 1'b0, 2, -1);

    // Empty run.
    run_seq(0, 1'b1, 1'b0, 0, -1);

    // Reset mid-run keeps the table.
    write_entry(0, rand_cfg());
    write_entry(1, rand_cfg());
    run_seq(2, 1'b1, 1'b1, 0, 3);

    // Randomized tables and traffic.
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < int'(ML); k++) write_entry(k, rand_cfg());
      run_seq($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
